serial_add_sub: RTL and testbench

- Bit-serial adder/subtractor for the Adder_Subtractor area of the library.
- Consumes one bit per clock through a single full-adder cell built from two half-adder stages. Trades latency for area compared with the parallel adders.
- Sits downstream of an operand source with a start/done handshake. Its registered result feeds wider arithmetic or display stages.

---
 rtl/add_sub_pkg.sv | 14 +
 rtl/fa_cell.sv | 21 ++
 rtl/serial_add_sub.sv | 122 ++++++++++++
 tb/tb_serial_add_sub.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: controller states
// and the operation encoding of the sub input.
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : add_sub_pkg

// File: rtl/fa_cell.sv
// Combinational full adder built from two half-adder stages; the single
// arithmetic cell reused every cycle by the serial datapath.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  assign s1   = a ^ b;
  assign c1   = a & b;
  assign s    = s1 ^ cin;
  assign c2   = s1 & cin;
  assign cout = c1 | c2;

endmodule : fa_cell

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one operand bit per clock through a single
// full-adder cell, with a start/done handshake and registered results.
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MSB  = CNT_W'(WIDTH - 2);

  state_e             state_q;
  logic [WIDTH-1:0]   a_sr_q;
  logic [WIDTH-1:0]   b_sr_q;
  logic [WIDTH-1:0]   r_sr_q;
  logic               c_ff_q;
  logic               c_msb_in_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               overflow_q;

  logic               bit_s;
  logic               bit_co;
  logic [WIDTH-1:0]   r_sr_d;

  fa_cell u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (c_ff_q),
    .s    (bit_s),
    .cout (bit_co)
  );

  // The new sum bit enters from the MSB side so that after WIDTH shifts the
  // first (LSB) result bit has arrived at position 0.
  assign r_sr_d = {bit_s, r_sr_q[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      r_sr_q     <= '0;
      c_ff_q     <= 1'b0;
      c_msb_in_q <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr_q  <= val1;
            b_sr_q  <= (sub == OP_SUB) ? ~val2 : val2;
            // Carry-in of 1 supplies the +1 of the two's-complement negate.
            c_ff_q  <= sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        RUN: begin
          r_sr_q <= r_sr_d;
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          c_ff_q <= bit_co;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_MSB) begin
            c_msb_in_q <= bit_co;
          end
          if (cnt_q == CNT_LAST) begin
            sum_q      <= r_sr_d;
            carry_q    <= bit_co;
            overflow_q <= bit_co ^ c_msb_in_q;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

endmodule : serial_add_sub

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] val1;
  logic [W-1:0] val2;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .val1     (val1),
    .val2     (val2),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: returns {overflow, carry, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] ref_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned full;
    logic [W-1:0] r;
    logic c;
    logic v;
    if (s) full = int'(a) + ((~int'(b)) & ((1 << W) - 1)) + 1;
    else   full = int'(a) + int'(b);
    r = full[W-1:0];
    c = full[W];
    if (s) v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    else   v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    return {v, c, r};
  endfunction

  // Present a start for one edge; returns at the negedge after the start edge.
  task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    sub   = s;
    val1  = a;
    val2  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Step negedges until done; n counts negedges since the start edge.
  task automatic wait_done(input string tag, inout int n, output int busy_cnt);
    busy_cnt = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    if (!done) check({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [W+1:0] exp);
    check({tag, "_sum"},   32'(sum),      32'(exp[W-1:0]));
    check({tag, "_carry"}, 32'(carry),    32'(exp[W]));
    check({tag, "_ovf"},   32'(overflow), 32'(exp[W+1]));
  endtask

  task automatic full_op(input string tag, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic check_timing);
    int n;
    int bc;
    start_op(s, a, b);
    n = 1;
    wait_done(tag, n, bc);
    if (check_timing) begin
      check({tag, "_latency"}, 32'(n), 32'(W + 1));
      check({tag, "_busycyc"}, 32'(bc), 32'(W));
    end
    check_result(tag, ref_op(s, a, b));
    @(negedge clk);
    check({tag, "_donepulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int bc;
    logic seen_done;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    val1  = '0;
    val2  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_ovf",  32'(overflow), 32'd0);

    // Directed vectors, checked against literal expected values.
    full_op("add_ovf", 1'b0, 8'h5A, 8'h3C, 1'b1);
    check("add_ovf_lit", 32'({overflow, carry, sum}), 32'({1'b1, 1'b0, 8'h96}));
    full_op("add_wrap", 1'b0, 8'hFF, 8'h01, 1'b1);
    check("add_wrap_lit", 32'({overflow, carry, sum}), 32'({1'b0, 1'b1, 8'h00}));
    full_op("sub_borrow", 1'b1, 8'h10, 8'h20, 1'b1);
    check("sub_borrow_lit", 32'({overflow, carry, sum}), 32'({1'b0, 1'b0, 8'hF0}));
    full_op("sub_ovf", 1'b1, 8'h80, 8'h01, 1'b1);
    check("sub_ovf_lit", 32'({overflow, carry, sum}), 32'({1'b1, 1'b1, 8'h7F}));

    // Start while busy is ignored; start in the done cycle is accepted.
    start_op(1'b0, 8'h01, 8'h02);
    n = 1;
    @(negedge clk);
    n++;
    start = 1'b1;
    val1  = 8'h7F;
    val2  = 8'h7F;
    @(negedge clk);
    n++;
    start = 1'b0;
    val1  = 8'h00;
    val2  = 8'h00;
    wait_done("busy_ign", n, bc);
    check("busy_ign_latency", 32'(n), 32'(W + 1));
    check("busy_ign_sum", 32'(sum), 32'h03);
    start = 1'b1;
    sub   = 1'b0;
    val1  = 8'h7F;
    val2  = 8'h7F;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done", 32'(done), 32'd0);
    n = 1;
    wait_done("b2b", n, bc);
    check("b2b_latency", 32'(n), 32'(W + 1));
    check("b2b_lit", 32'({overflow, carry, sum}), 32'({1'b1, 1'b0, 8'hFE}));

    // Reset mid-operation discards the partial result and all outputs.
    start_op(1'b0, 8'hAA, 8'h55);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum",  32'(sum),  32'd0);
    check("midrst_carry", 32'(carry), 32'd0);
    check("midrst_ovf",  32'(overflow), 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      seen_done |= done;
    end
    check("midrst_nodone", 32'(seen_done), 32'd0);
    full_op("after_rst", 1'b0, 8'hAA, 8'h55, 1'b1);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      full_op("rand", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_add_sub
